// File: rtl/karatsuba_split_sched_66bit_if.sv
// Operand-pair input / Karatsuba sub-pair output handshake bundle.
// master: the side that supplies operand pairs and drains sub-pairs.
// slave:  the split/schedule block itself.
interface karatsuba_split_sched_66bit_if #(
    parameter int unsigned n     = 66,
    parameter int unsigned TAG_W = 4
) ();

    localparam int unsigned h = n / 2;

    logic             in_valid;
    logic             in_ready;
    logic [n-1:0]     in_a;
    logic [n-1:0]     in_b;

    logic             out_valid;
    logic             out_ready;
    logic [h-1:0]     out_a;
    logic [h-1:0]     out_b;
    logic [1:0]       out_sel;
    logic             out_last;
    logic [TAG_W-1:0] out_tag;

    logic             busy;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_sel, out_last, out_tag, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_a, out_b, out_sel, out_last, out_tag, busy
    );

endinterface

// File: rtl/karatsuba_split_sched_66bit.sv
// Karatsuba operand splitter / sub-pair scheduler for a 66x66 GF(2) product.
// Latches one operand pair, then issues (lo, lo^hi, hi) half-width sub-pairs
// to a shared 33x33 sub-multiplier, one per output handshake, tagged per pair.
// Optional feature macro: KA_SPLIT_PIPE_EN -- accept the next pair in the
// cycle the high sub-pair hands off, removing the idle bubble between pairs.
module karatsuba_split_sched_66bit #(
    parameter int unsigned n     = 66,
    parameter int unsigned TAG_W = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    karatsuba_split_sched_66bit_if.slave  bus
);

    localparam int unsigned h = n / 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISS_LO  = 2'd1,
        ISS_MID = 2'd2,
        ISS_HI  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nx;

    logic [h-1:0]     a_lo;
    logic [h-1:0]     a_hi;
    logic [h-1:0]     b_lo;
    logic [h-1:0]     b_hi;

    logic [TAG_W-1:0] tag_cnt;
    logic [TAG_W-1:0] cur_tag;

    logic             in_ready_c;
    logic             busy_c;
    logic             accept_c;
    logic             issue_c;

    logic [h-1:0]     out_a_c;
    logic [h-1:0]     out_b_c;
    logic [1:0]       out_sel_c;
    logic             out_last_c;

    assign busy_c   = (state != IDLE);
    assign issue_c  = busy_c && bus.out_ready;
    assign accept_c = bus.in_valid && in_ready_c;

    // Input acceptance window; the pipelined build also opens it on the
    // high sub-pair's handoff cycle, creating an out_ready -> in_ready path.
`ifdef KA_SPLIT_PIPE_EN
    assign in_ready_c = (state == IDLE) || ((state == ISS_HI) && bus.out_ready);
`else
    assign in_ready_c = (state == IDLE);
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: each issue state advances only on an output handshake.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    state_nx = ISS_LO;
                end
            end
            ISS_LO: begin
                if (issue_c) begin
                    state_nx = ISS_MID;
                end
            end
            ISS_MID: begin
                if (issue_c) begin
                    state_nx = ISS_HI;
                end
            end
            ISS_HI: begin
                if (issue_c) begin
                    state_nx = accept_c ? ISS_LO : IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Operand halves captured on accept; untouched while not ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_lo <= '0;
            a_hi <= '0;
            b_lo <= '0;
            b_hi <= '0;
        end else if (accept_c) begin
            a_lo <= bus.in_a[h-1:0];
            a_hi <= bus.in_a[n-1:h];
            b_lo <= bus.in_b[h-1:0];
            b_hi <= bus.in_b[n-1:h];
        end
    end

    // Pair tag: running counter plus the copy frozen for the pair in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_cnt <= '0;
            cur_tag <= '0;
        end else if (accept_c) begin
            cur_tag <= tag_cnt;
            tag_cnt <= tag_cnt + TAG_W'(1);
        end
    end

    // Sub-pair decode from state and held operands; zero when idle.
    always_comb begin
        out_a_c    = '0;
        out_b_c    = '0;
        out_sel_c  = 2'd0;
        out_last_c = 1'b0;
        case (state)
            ISS_LO: begin
                out_a_c   = a_lo;
                out_b_c   = b_lo;
                out_sel_c = 2'd0;
            end
            ISS_MID: begin
                out_a_c   = a_lo ^ a_hi;
                out_b_c   = b_lo ^ b_hi;
                out_sel_c = 2'd1;
            end
            ISS_HI: begin
                out_a_c    = a_hi;
                out_b_c    = b_hi;
                out_sel_c  = 2'd2;
                out_last_c = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = busy_c;
    assign bus.busy      = busy_c;
    assign bus.out_a     = out_a_c;
    assign bus.out_b     = out_b_c;
    assign bus.out_sel   = out_sel_c;
    assign bus.out_last  = out_last_c;
    assign bus.out_tag   = cur_tag;

`ifndef SYNTHESIS
    // Selector code 3 is never produced.
    a_sel_legal: assert property (@(posedge clk) disable iff (rst) out_sel_c != 2'd3);
    // The last flag only appears on a valid sub-pair.
    a_last_valid: assert property (@(posedge clk) disable iff (rst) !out_last_c || busy_c);
`endif

endmodule

// File: tb/tb_karatsuba_split_sched_66bit.sv
// Bench for karatsuba_split_sched_66bit: queue-based reference of expected
// sub-pairs (lo, lo^hi, hi per accepted pair) with a modulo-16 tag model.
// Follows KA_SPLIT_PIPE_EN when defined.
module tb_karatsuba_split_sched_66bit;

`ifdef KA_SPLIT_PIPE_EN
    localparam bit PIPE = 1'b1;
`else
    localparam bit PIPE = 1'b0;
`endif

    typedef struct packed {
        logic [32:0] a;
        logic [32:0] b;
        logic [1:0]  sel;
        logic [3:0]  tag;
    } sub_t;

    logic clk;
    logic rst;

    karatsuba_split_sched_66bit_if #(.n(66), .TAG_W(4)) bus ();

    karatsuba_split_sched_66bit #(.n(66), .TAG_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    sub_t        q[$];
    int unsigned tag_m;
    int unsigned n_acc;
    int          n_vec;
    int          n_err;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [65:0] rand66();
        return {2'($urandom), 32'($urandom), 32'($urandom)};
    endfunction

    // Reference: block is ready when nothing is pending, or (pipelined) when
    // only the high sub-pair remains and it is being taken this cycle.
    function automatic logic rdy_m();
        return (q.size() == 0) || (PIPE && (q.size() == 1) && bus.out_ready);
    endfunction

    function automatic logic [75:0] expect_m();
        sub_t e;
        if (q.size() == 0)
            return {rdy_m(), 1'b0, 1'b0, 33'd0, 33'd0, 2'd0, 1'b0, 4'd0};
        e = q[0];
        return {rdy_m(), 1'b1, 1'b1, e.a, e.b, e.sel, (e.sel == 2'd2), e.tag};
    endfunction

    function automatic logic [75:0] observe();
        return {bus.in_ready, bus.out_valid, bus.busy, bus.out_a, bus.out_b,
                bus.out_sel, bus.out_last, (bus.out_valid ? bus.out_tag : 4'd0)};
    endfunction

    task automatic model_reset();
        q.delete();
        tag_m = 0;
    endtask

    task automatic push_pair(input logic [65:0] a, input logic [65:0] b);
        logic [32:0] alo, ahi, blo, bhi;
        alo = a[32:0];
        ahi = a[65:33];
        blo = b[32:0];
        bhi = b[65:33];
        q.push_back('{a: alo,       b: blo,       sel: 2'd0, tag: 4'(tag_m)});
        q.push_back('{a: alo ^ ahi, b: blo ^ bhi, sel: 2'd1, tag: 4'(tag_m)});
        q.push_back('{a: ahi,       b: bhi,       sel: 2'd2, tag: 4'(tag_m)});
        tag_m = (tag_m + 1) % 16;
        n_acc++;
    endtask

    // Advance the reference by one clock, then move to the next falling edge.
    task automatic tick();
        logic acc;
        logic ohs;
        sub_t tmp;
        acc = bus.in_valid && rdy_m();
        ohs = (q.size() != 0) && bus.out_ready;
        if (ohs) tmp = q.pop_front();
        if (acc) push_pair(bus.in_a, bus.in_b);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [65:0] a, input logic [65:0] b,
                         input logic ordy);
        bus.in_valid  = v;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.out_ready = ordy;
    endtask

    task automatic test_reset();
        logic [75:0] obs, exp;
        @(negedge clk);
        #1;
        obs = observe();
        n_vec++;
        if (obs !== {1'b1, 75'd0}) begin
            n_err++;
            $display("FAIL reset_held: got %h want %h", obs, {1'b1, 75'd0});
        end
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        drive(1'b1, rand66(), rand66(), 1'b1);
        for (int i = 0; i < 2; i++) begin
            #1;
            exp = expect_m();
            obs = observe();
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL reset_pre cyc%0d: got %h want %h", i, obs, exp);
            end
            tick();
            bus.in_valid = 1'b0;
        end
        #2;
        rst = 1'b1;
        #1;
        obs = observe();
        n_vec++;
        if (obs !== {1'b1, 75'd0}) begin
            n_err++;
            $display("FAIL reset_async: got %h want %h", obs, {1'b1, 75'd0});
        end
        model_reset();
        @(negedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [75:0] obs, exp;
        logic [72:0] tbl [3];
        logic [72:0] got;
        tbl[0] = {33'd5, 33'd2, 2'd0, 1'b0, 4'd0};
        tbl[1] = {33'd6, 33'd3, 2'd1, 1'b0, 4'd0};
        tbl[2] = {33'd3, 33'd1, 2'd2, 1'b1, 4'd0};
        drive(1'b1, 66'h0_0000_0006_0000_0005, 66'h0_0000_0002_0000_0002, 1'b1);
        for (int i = 0; i < 5; i++) begin
            #1;
            exp = expect_m();
            obs = observe();
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL basic cyc%0d: got %h want %h", i, obs, exp);
            end
            if (i >= 1 && i <= 3) begin
                got = {bus.out_a, bus.out_b, bus.out_sel, bus.out_last, bus.out_tag};
                n_vec++;
                if (got !== tbl[i-1]) begin
                    n_err++;
                    $display("FAIL basic_const sel%0d: got %h want %h", i - 1, got, tbl[i-1]);
                end
            end
            tick();
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        logic [75:0] obs, exp;
        drive(1'b1, rand66(), rand66(), 1'b1);
        for (int i = 0; i < 14; i++) begin
            #1;
            exp = expect_m();
            obs = observe();
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL backpressure cyc%0d: got %h want %h", i, obs, exp);
            end
            tick();
            if (i >= 1 && i <= 5) drive(1'b1, rand66(), rand66(), 1'b0);
            else                  drive(1'b0, rand66(), rand66(), 1'b1);
        end
    endtask

    task automatic test_tag_wrap();
        logic [75:0] obs, exp;
        int unsigned start;
        start = n_acc;
        for (int i = 0; i < 90; i++) begin
            drive((n_acc - start) < 17, rand66(), rand66(), 1'b1);
            #1;
            exp = expect_m();
            obs = observe();
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL tag_wrap cyc%0d: got %h want %h", i, obs, exp);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [75:0] obs, exp;
        int unsigned start;
        int first, last, span;
        start = n_acc;
        first = -1;
        last  = -1;
        for (int i = 0; i < 24; i++) begin
            drive((n_acc - start) < 4, rand66(), rand66(), 1'b1);
            #1;
            exp = expect_m();
            obs = observe();
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL back_to_back cyc%0d: got %h want %h", i, obs, exp);
            end
            if (bus.out_valid && bus.out_sel == 2'd0 && first < 0) first = i;
            if (bus.out_valid && bus.out_last) last = i;
            tick();
        end
        span = last - first;
        n_vec++;
        if (span != (PIPE ? 11 : 14)) begin
            n_err++;
            $display("FAIL back_to_back_span: got %0d want %0d", span, (PIPE ? 11 : 14));
        end
    endtask

    task automatic test_reset_mid();
        logic [75:0] obs, exp;
        logic [65:0] na;
        logic [38:0] got;
        logic [38:0] want;
        drive(1'b1, rand66(), rand66(), 1'b1);
        for (int i = 0; i < 2; i++) begin
            #1;
            exp = expect_m();
            obs = observe();
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL reset_mid_pre cyc%0d: got %h want %h", i, obs, exp);
            end
            tick();
            bus.in_valid = 1'b0;
        end
        #2;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        na = rand66();
        drive(1'b1, na, rand66(), 1'b1);
        for (int i = 0; i < 5; i++) begin
            #1;
            exp = expect_m();
            obs = observe();
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL reset_mid cyc%0d: got %h want %h", i, obs, exp);
            end
            if (i == 1) begin
                got  = {bus.out_valid, bus.out_a, bus.out_sel, bus.out_tag};
                want = {1'b1, na[32:0], 2'd0, 4'd0};
                n_vec++;
                if (got !== want) begin
                    n_err++;
                    $display("FAIL reset_mid_restart: got %h want %h", got, want);
                end
            end
            tick();
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic test_random();
        logic [75:0] obs, exp;
        for (int i = 0; i < 320; i++) begin
            if (i < 300) drive(($urandom_range(0, 1) == 1), rand66(), rand66(),
                               ($urandom_range(0, 9) < 7));
            else         drive(1'b0, rand66(), rand66(), 1'b1);
            #1;
            exp = expect_m();
            obs = observe();
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL random cyc%0d: got %h want %h", i, obs, exp);
            end
            tick();
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        n_acc = 0;
        rst   = 1'b1;
        model_reset();
        drive(1'b0, 66'd0, 66'd0, 1'b1);
        test_reset();
        test_basic();
        test_backpressure();
        test_tag_wrap();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
